// File: rtl/video_layer_compositor_pkg.sv
// Shared types and helpers for the video layer compositor: layer blend modes,
// the default SOLID colour and a per-channel half-intensity blend.
package video_comp_pkg;

   typedef enum logic [1:0] {
      MODE_OPAQUE = 2'b00,
      MODE_HALF   = 2'b01,
      MODE_INVERT = 2'b10,
      MODE_SOLID  = 2'b11
   } layer_mode_t;

   localparam logic [23:0] DEF_TEST_COLOR = 24'hFF7700;

   // Widest pixel the blend helper handles (three 32-bit channels).
   localparam int MAX_PIX_W = 96;

   // Per channel (a_c>>1)+(b_c>>1); each half is < 2^(ch_w-1), so no carry escapes.
   function automatic logic [MAX_PIX_W-1:0] half_blend(input logic [MAX_PIX_W-1:0] a,
                                                       input logic [MAX_PIX_W-1:0] b,
                                                       input int ch_w);
      logic [MAX_PIX_W-1:0] mask;
      logic [MAX_PIX_W-1:0] a_c;
      logic [MAX_PIX_W-1:0] b_c;
      logic [MAX_PIX_W-1:0] res;
      mask = {MAX_PIX_W{1'b1}} >> (MAX_PIX_W - ch_w);
      res  = '0;
      for (int c = 0; c < 3; c++) begin
         a_c = (a >> (c * ch_w)) & mask;
         b_c = (b >> (c * ch_w)) & mask;
         res = res | ((((a_c >> 1) + (b_c >> 1)) & mask) << (c * ch_w));
      end
      return res;
   endfunction

endpackage

// File: rtl/video_layer_compositor_if.sv
// Pixel, sideband and configuration bus between the video sources and the compositor.
// valid_in qualifies one pixel per cycle; there is no ready: the compositor always accepts.
interface video_comp_if #(
   parameter int NUM_BG     = 4,
   parameter int NUM_LAYERS = 3,
   parameter int PIXEL_W    = 24,
   parameter int SB_W       = 3
);
   import video_comp_pkg::*;

   localparam int BG_SEL_W = $clog2(NUM_BG);

   logic                        valid_in;
   logic                        new_frame_in;
   logic [NUM_BG*PIXEL_W-1:0]   bg_pixels_in;
   logic [NUM_LAYERS*PIXEL_W-1:0] layer_pixels_in;
   logic [NUM_LAYERS-1:0]       layer_hit_in;
   logic [SB_W-1:0]             sideband_in;
   logic                        cfg_wr_in;
   logic [BG_SEL_W-1:0]         cfg_bg_sel_in;
   logic [NUM_LAYERS-1:0]       cfg_layer_en_in;
   logic [2*NUM_LAYERS-1:0]     cfg_layer_mode_in;
   logic [PIXEL_W-1:0]          pixel_out;
   logic [SB_W-1:0]             sideband_out;
   logic                        valid_out;
   logic                        cfg_pending_out;

   modport master (
      output valid_in, new_frame_in, bg_pixels_in, layer_pixels_in, layer_hit_in,
             sideband_in, cfg_wr_in, cfg_bg_sel_in, cfg_layer_en_in, cfg_layer_mode_in,
      input  pixel_out, sideband_out, valid_out, cfg_pending_out
   );

   modport slave (
      input  valid_in, new_frame_in, bg_pixels_in, layer_pixels_in, layer_hit_in,
             sideband_in, cfg_wr_in, cfg_bg_sel_in, cfg_layer_en_in, cfg_layer_mode_in,
      output pixel_out, sideband_out, valid_out, cfg_pending_out
   );

endinterface

// File: rtl/video_layer_compositor_layer_blend.sv
// One overlay layer: combines the colour beneath with this layer's colour
// according to its blend mode when the layer covers the pixel.
module layer_blend
   import video_comp_pkg::*;
#(
   parameter int                 PIXEL_W    = 24,
   parameter logic [PIXEL_W-1:0] TEST_COLOR = PIXEL_W'(DEF_TEST_COLOR)
) (
   input  logic [PIXEL_W-1:0] i_under,
   input  logic [PIXEL_W-1:0] i_layer,
   input  logic               i_hit,
   input  layer_mode_t        i_mode,
   output logic [PIXEL_W-1:0] o_under
);

   localparam int CH_W = PIXEL_W / 3;

   always_comb begin
      o_under = i_under;
      if (i_hit) begin
         case (i_mode)
            MODE_OPAQUE: o_under = i_layer;
            MODE_HALF:   o_under = PIXEL_W'(half_blend(MAX_PIX_W'(i_under),
                                                       MAX_PIX_W'(i_layer), CH_W));
            MODE_INVERT: o_under = ~i_under;
            MODE_SOLID:  o_under = TEST_COLOR;
            default:     o_under = i_under;
         endcase
      end
   end

endmodule

// File: rtl/video_layer_compositor.sv
// Two-stage pixel compositor: background select, then a priority chain of overlay
// layers. Configuration is double-buffered and swapped on the first valid pixel of a frame.
module video_layer_compositor
   import video_comp_pkg::*;
#(
   parameter int                 NUM_BG     = 4,
   parameter int                 NUM_LAYERS = 3,
   parameter int                 PIXEL_W    = 24,
   parameter int                 SB_W       = 3,
   parameter logic [PIXEL_W-1:0] TEST_COLOR = PIXEL_W'(DEF_TEST_COLOR)
) (
   input logic        clk_in,
   input logic        rst_in,
   video_comp_if.slave bus
);

   localparam int BG_SEL_W = $clog2(NUM_BG);

   logic [BG_SEL_W-1:0]       r_pend_bg_sel, r_act_bg_sel;
   logic [NUM_LAYERS-1:0]     r_pend_en, r_act_en;
   logic [2*NUM_LAYERS-1:0]   r_pend_mode, r_act_mode;
   logic                      r_cfg_pending;

   logic                      w_apply;
   logic [BG_SEL_W-1:0]       w_eff_bg_sel;
   logic [NUM_LAYERS-1:0]     w_eff_en;
   logic [2*NUM_LAYERS-1:0]   w_eff_mode;
   logic [PIXEL_W-1:0]        w_bg;

   logic [PIXEL_W-1:0]            r_s1_bg;
   logic [NUM_LAYERS*PIXEL_W-1:0] r_s1_layers;
   logic [NUM_LAYERS-1:0]         r_s1_hit;
   logic [2*NUM_LAYERS-1:0]       r_s1_mode;
   logic [SB_W-1:0]               r_s1_sb;
   logic                          r_s1_valid;

   logic [PIXEL_W-1:0]        w_under [NUM_LAYERS+1];
   logic [PIXEL_W-1:0]        r_s2_pix;
   logic [SB_W-1:0]           r_s2_sb;
   logic                      r_s2_valid;

   // The frame's first pixel already sees the pending set, so the swap is seamless.
   assign w_apply      = bus.valid_in & bus.new_frame_in & r_cfg_pending;
   assign w_eff_bg_sel = w_apply ? r_pend_bg_sel : r_act_bg_sel;
   assign w_eff_en     = w_apply ? r_pend_en     : r_act_en;
   assign w_eff_mode   = w_apply ? r_pend_mode   : r_act_mode;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_pend_bg_sel <= '0;
         r_pend_en     <= '0;
         r_pend_mode   <= '0;
         r_act_bg_sel  <= '0;
         r_act_en      <= '0;
         r_act_mode    <= '0;
         r_cfg_pending <= 1'b0;
      end else begin
         if (w_apply) begin
            r_act_bg_sel <= r_pend_bg_sel;
            r_act_en     <= r_pend_en;
            r_act_mode   <= r_pend_mode;
         end
         if (bus.cfg_wr_in) begin
            r_pend_bg_sel <= bus.cfg_bg_sel_in;
            r_pend_en     <= bus.cfg_layer_en_in;
            r_pend_mode   <= bus.cfg_layer_mode_in;
            r_cfg_pending <= 1'b1;
         end else if (w_apply) begin
            r_cfg_pending <= 1'b0;
         end
      end
   end

   // Selects that name no source fall back to source 0.
   always_comb begin
      w_bg = bus.bg_pixels_in[0 +: PIXEL_W];
      for (int k = 1; k < NUM_BG; k++) begin
         if (w_eff_bg_sel == BG_SEL_W'(k)) w_bg = bus.bg_pixels_in[k*PIXEL_W +: PIXEL_W];
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_s1_bg     <= '0;
         r_s1_layers <= '0;
         r_s1_hit    <= '0;
         r_s1_mode   <= '0;
         r_s1_sb     <= '0;
         r_s1_valid  <= 1'b0;
      end else begin
         r_s1_bg     <= w_bg;
         r_s1_layers <= bus.layer_pixels_in;
         r_s1_hit    <= bus.layer_hit_in & w_eff_en;
         r_s1_mode   <= w_eff_mode;
         r_s1_sb     <= bus.sideband_in;
         r_s1_valid  <= bus.valid_in;
      end
   end

   assign w_under[0] = r_s1_bg;

   for (genvar i = 0; i < NUM_LAYERS; i++) begin : g_layer
      layer_blend #(
         .PIXEL_W    (PIXEL_W),
         .TEST_COLOR (TEST_COLOR)
      ) u_blend (
         .i_under (w_under[i]),
         .i_layer (r_s1_layers[i*PIXEL_W +: PIXEL_W]),
         .i_hit   (r_s1_hit[i]),
         .i_mode  (layer_mode_t'(r_s1_mode[2*i +: 2])),
         .o_under (w_under[i+1])
      );
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_s2_pix   <= '0;
         r_s2_sb    <= '0;
         r_s2_valid <= 1'b0;
      end else begin
         r_s2_pix   <= w_under[NUM_LAYERS];
         r_s2_sb    <= r_s1_sb;
         r_s2_valid <= r_s1_valid;
      end
   end

   // Syncs keep flowing during blanking; only the colour is blanked.
   assign bus.pixel_out       = r_s2_valid ? r_s2_pix : '0;
   assign bus.sideband_out    = r_s2_sb;
   assign bus.valid_out       = r_s2_valid;
   assign bus.cfg_pending_out = r_cfg_pending;

endmodule

// File: doc/video_layer_compositor.md
Name: video_layer_compositor

Overview:
- Parametrised, pipelined successor to the pixel-path video mux.
- Selects one of NUM_BG background sources, then composites NUM_LAYERS overlay layers on top in fixed priority (highest index on top). Each layer has its own enable and blend mode.
- Configuration writes are double-buffered and take effect only at a frame boundary, so a mode change never tears mid-frame.
- Sits between the camera/threshold/sprite generators and the HDMI/TMDS encoder; sideband (syncs, active-draw) is delayed to stay aligned with the pixel.

Parameters:
- NUM_BG, 4: number of background sources. Minimum 2.
- NUM_LAYERS, 3: number of overlay layers. Range 1..8.
- PIXEL_W, 24: pixel width. Must be divisible by 3; CH_W = PIXEL_W/3.
- SB_W, 3: width of sideband passed alongside pixels.
- TEST_COLOR, 24'hFF7700: colour used by the SOLID mode.

Ports:
- clk_in  input  1  pixel clock.
- rst_in  input  1  synchronous, active-high reset.
- valid_in  input  1  input pixel qualifier.
- new_frame_in  input  1  first pixel of a frame; only meaningful when valid_in=1.
- bg_pixels_in  input  NUM_BG*PIXEL_W  background sources; source k is at bits [k*PIXEL_W +: PIXEL_W].
- layer_pixels_in  input  NUM_LAYERS*PIXEL_W  overlay colours, packed the same way.
- layer_hit_in  input  NUM_LAYERS  layer i covers this pixel.
- sideband_in  input  SB_W  hsync/vsync/active_draw, passed through.
- cfg_wr_in  input  1  one-cycle strobe that loads the pending configuration.
- cfg_bg_sel_in  input  $clog2(NUM_BG)  background select.
- cfg_layer_en_in  input  NUM_LAYERS  per-layer enable.
- cfg_layer_mode_in  input  2*NUM_LAYERS  per-layer mode; layer i uses bits [2i+1:2i].
- pixel_out  output  PIXEL_W  composited pixel.
- sideband_out  output  SB_W  delayed sideband.
- valid_out  output  1  delayed valid_in.
- cfg_pending_out  output  1  a written configuration has not yet been applied.

Behaviour:
- Reset:
  - pixel_out, sideband_out, valid_out and cfg_pending_out are 0.
  - Active and pending configuration: bg_sel=0, all layers disabled, all modes OPAQUE.
  - Both pipeline stages are cleared. Reset mid-frame discards in-flight pixels.
- Latency:
  - Fixed 2 cycles from input to pixel_out/sideband_out/valid_out.
  - The pipeline advances every cycle; there is no stall.
- Configuration double-buffer:
  - cfg_wr_in=1 loads the pending registers from the cfg_* inputs and sets cfg_pending_out on the next cycle.
  - apply = valid_in & new_frame_in & cfg_pending. On apply, pending is copied to active and cfg_pending_out clears.
  - The pixel carrying new_frame_in is the first pixel that uses the new configuration: stage 1 uses pending directly on apply.
  - cfg_wr_in and apply in the same cycle: apply uses the old pending contents; the new write is captured into pending and cfg_pending_out stays 1.
  - Repeated writes before a frame boundary: last write wins.
- Stage 1 (registered):
  - bg = bg_pixels_in[eff_bg_sel].
  - eff_bg_sel >= NUM_BG selects source 0.
  - Layer pixels, effective hits (hit & en), modes, sideband and valid are registered alongside bg.
- Stage 2 (registered), chained from layer 0 (bottom) to layer NUM_LAYERS-1 (top):
  - under starts as bg. Each layer with effective hit=1 replaces under according to its mode.
  - 2'b00 OPAQUE: under = layer pixel.
  - 2'b01 HALF: per channel, (under_c>>1)+(layer_c>>1). Truncating, no overflow, width CH_W.
  - 2'b10 INVERT: under = ~under. The layer colour is ignored.
  - 2'b11 SOLID: under = TEST_COLOR[PIXEL_W-1:0].
  - Layers with effective hit=0 pass under unchanged.
- Output gating:
  - When the stage-2 valid is 0, pixel_out = 0.
  - sideband_out is always passed through, regardless of valid.
- new_frame_in with valid_in=0 is ignored and no apply occurs.

Decomposition:
- Package video_comp_pkg:
  - enum layer_mode_t {MODE_OPAQUE, MODE_HALF, MODE_INVERT, MODE_SOLID} (2 bits).
  - Function half_blend(a, b) on a packed pixel.
  - Default TEST_COLOR constant.
- Sub-module layer_blend (combinational, one instance per layer, chained by generate):
  - Inputs: under, layer pixel, hit, mode.
  - Output: the new under.

Test Plan:
- Reset, then valid_in=1 with bg source 0 = 24'h123456 and no writes -> pixel_out = 24'h123456 two cycles later; cfg_pending_out=0; valid_out tracks valid_in delayed by 2.
- cfg_wr_in with bg_sel=2, with bg2 = 24'hABCDEF, issued mid-frame -> cfg_pending_out=1 and output unchanged until the new_frame_in pixel. That pixel and all later ones output 24'hABCDEF; cfg_pending_out drops.
- All layers enabled, hits asserted:
  - L0 OPAQUE 24'h00FF00, L1 HALF 24'hFF0000, L2 off, bg 24'h0000FF -> pixel_out = 24'h7F7F00.
  - Same, with L2 enabled in INVERT -> pixel_out = 24'h8080FF.
- L2 in SOLID mode with hit=1 over any lower layers -> 24'hFF7700. Same with hit=0 -> lower result unchanged.
- cfg_wr_in asserted in the same cycle as new_frame_in while pending -> the old pending config is applied and cfg_pending_out stays 1; the second config is applied at the next new_frame_in.
- valid_in=0 with sideband_in=3'b101 -> two cycles later pixel_out=0, sideband_out=3'b101, valid_out=0. rst_in asserted with pixels in flight -> all outputs 0 the next cycle.
